// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU types: HI/LO unit operation encoding and sequencer states.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// Request/result bundle between the CPU core (master) and the HI/LO multiply-divide unit (slave).
interface mips_cpu_muldiv_if #(parameter int WIDTH = 32);
    import mips_cpu_pkg::*;

    logic             clk_enable;
    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_write;
    logic             lo_write;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output clk_enable, start, op, a, b, hi_write, lo_write, wr_data,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  clk_enable, start, op, a, b, hi_write, lo_write, wr_data,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/mips_cpu_muldiv_signfix.sv
// Two's-complement conditional negate: magnitude of signed operands and sign restore of results.
module mips_cpu_muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? -value : value;

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle on magnitudes, sign fixed up afterwards.
// Defining MIPS_MULDIV_EARLY_TERM_EN lets multiplies leave RUN once the multiplier is exhausted.
module mips_cpu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    mips_cpu_muldiv_if.slave    bus
);
    import mips_cpu_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);
    localparam int W2    = 2 * WIDTH;

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q, op_d;
    logic [W2-1:0]    prod_q, prod_d;
    logic [W2-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;
    logic             last_run;

    mips_cpu_muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (
        .value(bus.a), .negate(op_is_signed(bus.op) & bus.a[WIDTH-1]), .result(a_mag));
    mips_cpu_muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (
        .value(bus.b), .negate(op_is_signed(bus.op) & bus.b[WIDTH-1]), .result(b_mag));
    mips_cpu_muldiv_signfix #(.WIDTH(W2)) u_fix_prod (
        .value(prod_q), .negate(neg_res_q), .result(prod_fix));
    mips_cpu_muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo (
        .value(prod_q[WIDTH-1:0]), .negate(neg_res_q), .result(quo_fix));
    mips_cpu_muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
        .value(prod_q[W2-1:WIDTH]), .negate(neg_rem_q), .result(rem_fix));

    // Restoring divide: remainder always fits WIDTH bits, so the shifted trial value needs one extra.
    assign div_shift = prod_q[W2-1:WIDTH-1];
    assign div_diff  = {1'b0, div_shift} - {2'b00, mcand_q[WIDTH-1:0]};
    assign div_ok    = ~div_diff[WIDTH+1];

`ifdef MIPS_MULDIV_EARLY_TERM_EN
    assign last_run = op_is_div(op_q) ? (count_q == CNT_W'(WIDTH - 1))
                                      : (mplier_q[WIDTH-1:1] == '0);
`else
    assign last_run = (count_q == CNT_W'(WIDTH - 1));
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d   = state_q;
        op_d      = op_q;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d      = bus.op;
                    count_d   = '0;
                    neg_res_d = op_is_signed(bus.op) & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_rem_d = op_is_signed(bus.op) & bus.a[WIDTH-1];
                    if (op_is_div(bus.op) && (bus.b == '0)) begin
                        state_d = ST_DONE;
                        hi_d    = bus.a;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d  = ST_RUN;
                        dbz_d    = 1'b0;
                        mplier_d = b_mag;
                        if (op_is_div(bus.op)) begin
                            mcand_d = {{WIDTH{1'b0}}, b_mag};
                            prod_d  = {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            mcand_d = {{WIDTH{1'b0}}, a_mag};
                            prod_d  = '0;
                        end
                    end
                end else begin
                    if (bus.hi_write) hi_d = bus.wr_data;
                    if (bus.lo_write) lo_d = bus.wr_data;
                end
            end
            ST_RUN: begin
                count_d = count_q + 1'b1;
                if (op_is_div(op_q)) begin
                    prod_d = {div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0],
                              prod_q[WIDTH-2:0], div_ok};
                end else begin
                    prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                if (last_run) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_DONE;
                if (op_is_div(op_q)) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MULT;
            prod_q    <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
        end else if (bus.clk_enable) begin
            state_q   <= state_d;
            op_q      <= op_d;
            prod_q    <= prod_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed checks of the HI/LO multiply/divide unit: results, latency, MTHI/MTLO, stalls, reset.
module tb_mips_cpu_muldiv;
    import mips_cpu_pkg::*;

`ifdef MIPS_MULDIV_EARLY_TERM_EN
    localparam int LAT_B1 = 3;
    localparam int LAT_B3 = 4;
    localparam int LAT_B7 = 5;
`else
    localparam int LAT_B1 = 34;
    localparam int LAT_B3 = 34;
    localparam int LAT_B7 = 34;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mips_cpu_muldiv_if #(.WIDTH(32)) bus ();

    mips_cpu_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Returns in the first cycle done is seen (lat = cycle number after acceptance, 0 on timeout).
    task automatic run_op(input muldiv_op_t o, input logic [31:0] ra, input logic [31:0] rb,
                          input bit with_mt, input int inject_at, input int stall_at,
                          output int lat, output logic [31:0] hi_c1);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = o;
        bus.a        = ra;
        bus.b        = rb;
        bus.hi_write = with_mt;
        bus.lo_write = with_mt;
        bus.wr_data  = 32'hDEAD_0000;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.hi_write = 1'b0;
        bus.lo_write = 1'b0;
        hi_c1 = bus.hi;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            if (n == inject_at + 1) begin
                bus.start    = 1'b0;
                bus.hi_write = 1'b0;
            end
            if (n == stall_at + 3) bus.clk_enable = 1'b1;
            if (bus.done) begin
                lat = n;
                break;
            end
            if (n == inject_at) begin
                bus.start    = 1'b1;
                bus.op       = OP_MULTU;
                bus.a        = 32'd1;
                bus.b        = 32'd1;
                bus.hi_write = 1'b1;
                bus.wr_data  = 32'h1234;
            end
            if (n == stall_at) bus.clk_enable = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int          lat;
        int          pulses;
        logic [31:0] hi_c1;

        n_checks = 0;
        n_fail   = 0;
        reset          = 1'b0;
        bus.clk_enable = 1'b1;
        bus.start      = 1'b0;
        bus.op         = OP_MULT;
        bus.a          = '0;
        bus.b          = '0;
        bus.hi_write   = 1'b0;
        bus.lo_write   = 1'b0;
        bus.wr_data    = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        reset = 1'b1;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, lat, hi_c1);
        check("multu_max_lat", 64'(lat), 64'd34);
        check("multu_max_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        check("multu_max_lo", 64'(bus.lo), 64'h0000_0001);
        check("multu_max_busy_done", 64'(bus.busy), 64'd1);
        @(negedge clk);
        check("multu_max_done_drop", 64'(bus.done), 64'd0);
        check("multu_max_idle", 64'(bus.busy), 64'd0);

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 0, 0, lat, hi_c1);
        check("mult_neg_lat", 64'(lat), 64'(LAT_B7));
        check("mult_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_neg_lo", 64'(bus.lo), 64'hFFFF_FFEB);

        run_op(OP_MULTU, 32'd5, 32'd1, 1'b0, 0, 0, lat, hi_c1);
        check("multu_5x1_lat", 64'(lat), 64'(LAT_B1));
        check("multu_5x1_hi", 64'(bus.hi), 64'd0);
        check("multu_5x1_lo", 64'(bus.lo), 64'd5);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 0, lat, hi_c1);
        check("div_neg_lat", 64'(lat), 64'd34);
        check("div_neg_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        check("div_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, lat, hi_c1);
        check("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
        check("div_ovf_hi", 64'(bus.hi), 64'd0);

        run_op(OP_DIVU, 32'd100, 32'd0, 1'b0, 0, 0, lat, hi_c1);
        check("divz_lat", 64'(lat), 64'd1);
        check("divz_hi", 64'(bus.hi), 64'h64);
        check("divz_lo", 64'(bus.lo), 64'hFFFF_FFFF);
        check("divz_flag", 64'(bus.div_by_zero), 64'd1);
        check("divz_busy", 64'(bus.busy), 64'd1);

        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 0, 0, lat, hi_c1);
        check("divu_lat", 64'(lat), 64'd34);
        check("divu_lo", 64'(bus.lo), 64'd14);
        check("divu_hi", 64'(bus.hi), 64'd2);
        check("divu_flag_clear", 64'(bus.div_by_zero), 64'd0);

        @(negedge clk);
        bus.hi_write = 1'b1;
        bus.wr_data  = 32'hCAFE_0001;
        @(negedge clk);
        bus.hi_write = 1'b0;
        bus.lo_write = 1'b1;
        bus.wr_data  = 32'hBEEF_0002;
        check("mthi", 64'(bus.hi), 64'hCAFE_0001);
        @(negedge clk);
        bus.lo_write = 1'b0;
        check("mtlo", 64'(bus.lo), 64'hBEEF_0002);
        check("mtlo_hi_kept", 64'(bus.hi), 64'hCAFE_0001);

        run_op(OP_MULTU, 32'd2, 32'd3, 1'b1, 0, 0, lat, hi_c1);
        check("prio_start_over_mt", 64'(hi_c1), 64'hCAFE_0001);
        check("prio_lat", 64'(lat), 64'(LAT_B3));
        check("prio_lo", 64'(bus.lo), 64'd6);
        check("prio_hi", 64'(bus.hi), 64'd0);

        run_op(OP_DIVU, 32'd1000, 32'd7, 1'b0, 10, 0, lat, hi_c1);
        check("inject_lat", 64'(lat), 64'd34);
        check("inject_lo", 64'(bus.lo), 64'd142);
        check("inject_hi", 64'(bus.hi), 64'd6);
        @(negedge clk);
        check("inject_no_restart", 64'(bus.busy), 64'd0);

        run_op(OP_DIVU, 32'd1000, 32'd7, 1'b0, 0, 5, lat, hi_c1);
        check("stall_lat", 64'(lat), 64'd37);
        check("stall_lo", 64'(bus.lo), 64'd142);

        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd1000;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_reset_busy", 64'(bus.busy), 64'd0);
        check("mid_reset_done", 64'(bus.done), 64'd0);
        check("mid_reset_hi", 64'(bus.hi), 64'd0);
        check("mid_reset_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("post_reset_no_done", 64'(pulses), 64'd0);

        run_op(OP_MULTU, 32'd2, 32'd3, 1'b0, 0, 0, lat, hi_c1);
        check("post_reset_lat", 64'(lat), 64'(LAT_B3));
        check("post_reset_lo", 64'(bus.lo), 64'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
